vec_issue_ctrl: RTL and testbench
=================================

# vec_issue_ctrl

Sequencing controller for the vector processor datapath. Accepts one instruction at a time from the scalar core over a valid/ready handshake, classifies it (config/CSR, arithmetic, load, store), and drives every datapath control signal for the duration of execution. It completes when the datapath reports completion, and returns a one-cycle acknowledge (with error flag) to the scalar core. A watchdog guards against a datapath that never completes.

## Interface
- `XLEN`, 32, instruction/scalar width
- `TIMEOUT`, 1024, max EXEC cycles before watchdog abort (≥2)
- `clk`  in  1  clock
- `reset`  in  1  reset, asynchronous, active-high
- `inst_valid`  in  1  scalar core presents `instruction`
- `instruction`  in  XLEN  vector instruction
- `inst_ready`  out  1  controller can accept (IDLE only)
- `is_vec`  in  1  decoder legality flag for the captured instruction
- `dp_done`  in  1  datapath completion (register write done or CSR done)
- `inst_ack`  out  1  one-cycle completion pulse
- `inst_err`  out  1  qualifies `inst_ack`: illegal or timed out
- `busy`  out  1  high whenever state ≠ IDLE
- `vl_sel`, `vtype_sel`, `lumop_sel`, `rs1rd_de`, `rs1_sel`  out  1 each  decode selects
- `csrwr_en`  out  1  CSR write strobe
- `vec_reg_wr_en`, `mask_operation`, `mask_wr_en`  out  1 each  register file controls
- `data_mux1_sel`  out  2  00 vs1, 01 scalar1, 10 immediate
- `data_mux2_sel`  out  1  0 vs2, 1 scalar2
- `stride_sel`, `ld_inst`, `st_inst`, `index_str`, `index_unordered`  out  1 each  LSU controls

## Operation
- States: IDLE, DECODE, EXEC, DONE.
- IDLE: `inst_ready`=1. `inst_valid`=1 captures `instruction` into an internal register and moves to DECODE.
- DECODE (1 cycle): classify the captured instruction.
  - Illegal when any of: `is_vec`=0; opcode ∉ {0x57, 0x07, 0x27}; load/store width ∉ {000,101,110,111}.
  - Illegal → DONE with error.
  - Otherwise the control vector is registered and the state moves to EXEC.
- Config class (opcode 0x57, funct3 111):
  - `vl_sel`=1 iff inst[31:30]=11 (vsetivli).
  - `vtype_sel`=1 iff inst[31:25]=1000000 (vsetvl).
  - `rs1rd_de`=1 iff rs1=0 and rd≠0.
  - `rs1_sel`=1.
  - `csrwr_en` pulses for the first EXEC cycle only.
- Arithmetic class (0x57, other funct3):
  - `data_mux1_sel`: funct3 000/001 → 00; 100/101/110 → 01; 011 → 10.
  - `data_mux2_sel`=0.
  - `vec_reg_wr_en`=1.
  - `mask_operation`=~inst[25].
- Load class (0x07) and store class (0x27):
  - `ld_inst`=1 for loads; `st_inst`=1 for stores.
  - `vec_reg_wr_en`=1 for loads only.
  - mop=inst[27:26]. `stride_sel`=1 iff mop=00, and then `lumop_sel`=1. `index_str`=mop[0]. `index_unordered`=1 iff mop=01.
- EXEC: control vector held constant.
  - `dp_done`=1 → DONE without error.
  - Watchdog counter reaches TIMEOUT-1 without `dp_done` → DONE with error.
- DONE (1 cycle): `inst_ack`=1, `inst_err` as determined, all controls 0. Next state IDLE.
- All datapath controls are 0 outside EXEC.

## Timing
- Reset: state IDLE; `inst_ready`=1; all other outputs 0; watchdog cleared; captured instruction cleared.
- Handshake at cycle 0 → DECODE in cycle 1 → controls valid from cycle 2 (first EXEC cycle).
- `dp_done` is sampled every EXEC cycle, including the first. `dp_done` sampled at edge N → `inst_ack` high during cycle N+1 → `inst_ready` high during cycle N+2.
- Minimum legal-instruction latency from handshake to ack: 3 cycles. Illegal instruction: ack+err in cycle 2.
- `inst_valid` outside IDLE is ignored; the instruction is not captured.
- `dp_done` outside EXEC is ignored.
- Timeout and `dp_done` in the same cycle: completion wins, `inst_err`=0.
- Watchdog: counts EXEC cycles from 0, saturates, and is cleared on EXEC entry.
- Reset mid-operation: immediate return to reset values. No ack is issued for the aborted instruction.

## Structure
- Package `vec_ctrl_pkg`:
  - state enum and instruction-class enum (CFG, ARITH, LOAD, STORE, ILLEGAL);
  - opcode constants 0x57/0x07/0x27;
  - packed struct `vec_ctrl_t` holding all datapath controls.
- Sub-module `vec_ctrl_decode`: combinational, instruction + `is_vec` → class + `vec_ctrl_t`. The FSM registers its output.

## Test plan
- Reset mid-EXEC of a load → next cycle all controls 0, `busy`=0, `inst_ready`=1, no `inst_ack`.
- Config: `0x010572D7` (vsetvli x5,x10,e32m1), `dp_done` on the 2nd EXEC cycle.
  - `csrwr_en` high for exactly one cycle; `vl_sel`=0, `vtype_sel`=0, `rs1rd_de`=0.
  - ack, err=0, 4 cycles after the handshake.
- Arithmetic: `0x022180D7` (vadd.vv v1,v2,v3), `dp_done` on the first EXEC cycle.
  - `data_mux1_sel`=00, `vec_reg_wr_en`=1, `mask_operation`=0.
  - ack in cycle 3.
- Load: `0x0205E207` (vle32.v v4,(x11)).
  - `ld_inst`=1, `stride_sel`=1, `lumop_sel`=1, `index_str`=0, `vec_reg_wr_en`=1, held stable until `dp_done`.
- Illegal: `0x00000013` with `is_vec`=0 → `inst_ack`=1, `inst_err`=1 in cycle 2; no control ever asserted.
- Watchdog: TIMEOUT=16, store never completes → err ack after 16 EXEC cycles. With `dp_done` on the 16th EXEC cycle → err=0.

Source files
------------

// File: rtl/vec_ctrl_pkg.sv
// vec_ctrl_pkg: shared states, instruction classes, opcodes and control bundle for the vector issue controller
package vec_ctrl_pkg;
   localparam logic [6:0] OP_V  = 7'h57;
   localparam logic [6:0] OP_LD = 7'h07;
   localparam logic [6:0] OP_ST = 7'h27;
   typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_DONE} state_e;
   typedef enum logic [2:0] {CLS_CFG, CLS_ARITH, CLS_LOAD, CLS_STORE, CLS_ILLEGAL} cls_e;
   typedef struct packed {
      logic       vl_sel;
      logic       vtype_sel;
      logic       lumop_sel;
      logic       rs1rd_de;
      logic       rs1_sel;
      logic       csrwr_en;
      logic       vec_reg_wr_en;
      logic       mask_operation;
      logic       mask_wr_en;
      logic [1:0] data_mux1_sel;
      logic       data_mux2_sel;
      logic       stride_sel;
      logic       ld_inst;
      logic       st_inst;
      logic       index_str;
      logic       index_unordered;
   } vec_ctrl_t;
   function automatic logic ls_width_ok(input logic [2:0] w);
      return w inside {3'b000, 3'b101, 3'b110, 3'b111};
   endfunction
endpackage

// File: rtl/vec_issue_ctrl_if.sv
// vec_issue_ctrl_if: scalar-core issue handshake between the core (master) and the controller (slave)
interface vec_issue_ctrl_if #(parameter int XLEN = 32);
   logic            inst_valid;
   logic [XLEN-1:0] instruction;
   logic            inst_ready;
   logic            is_vec;
   logic            inst_ack;
   logic            inst_err;
   logic            busy;
   modport master (output inst_valid, instruction, is_vec, input inst_ready, inst_ack, inst_err, busy);
   modport slave (input inst_valid, instruction, is_vec, output inst_ready, inst_ack, inst_err, busy);
endinterface

// File: rtl/vec_ctrl_decode.sv
// vec_ctrl_decode: combinational classifier mapping an instruction to its class and datapath control vector
module vec_ctrl_decode import vec_ctrl_pkg::*; (
   input  logic [31:0] inst,
   input  logic        is_vec,
   output cls_e        cls,
   output vec_ctrl_t   ctrl
);
   logic [6:0] opc;
   logic [2:0] f3;
   logic [1:0] mop;
   logic       unused_bits;
   assign opc = inst[6:0];
   assign f3 = inst[14:12];
   assign mop = inst[27:26];
   assign unused_bits = ^inst[24:20];
   always_comb begin
      ctrl = '0;
      cls = !is_vec ? CLS_ILLEGAL :
            opc == OP_V ? (f3 == 3'b111 ? CLS_CFG : CLS_ARITH) :
            (opc == OP_LD || opc == OP_ST) && ls_width_ok(f3) ? (opc == OP_LD ? CLS_LOAD : CLS_STORE) :
            CLS_ILLEGAL;
      case (cls)
         CLS_CFG: begin
            ctrl.vl_sel = inst[31:30] == 2'b11;
            ctrl.vtype_sel = inst[31:25] == 7'b1000000;
            ctrl.rs1rd_de = inst[19:15] == 5'd0 && inst[11:7] != 5'd0;
            ctrl.rs1_sel = 1'b1;
            ctrl.csrwr_en = 1'b1;
         end
         CLS_ARITH: begin
            ctrl.data_mux1_sel = f3 inside {3'b100, 3'b101, 3'b110} ? 2'b01 : f3 == 3'b011 ? 2'b10 : 2'b00;
            ctrl.vec_reg_wr_en = 1'b1;
            ctrl.mask_operation = ~inst[25];
         end
         CLS_LOAD, CLS_STORE: begin
            ctrl.ld_inst = cls == CLS_LOAD;
            ctrl.st_inst = cls == CLS_STORE;
            ctrl.vec_reg_wr_en = cls == CLS_LOAD;
            ctrl.stride_sel = mop == 2'b00;
            ctrl.lumop_sel = mop == 2'b00;
            ctrl.index_str = mop[0];
            ctrl.index_unordered = mop == 2'b01;
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/vec_issue_ctrl.sv
// vec_issue_ctrl: issue FSM sequencing one vector instruction through decode, execute and acknowledge
module vec_issue_ctrl import vec_ctrl_pkg::*; #(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 1024
) (
   input  logic             clk,
   input  logic             reset,
   vec_issue_ctrl_if.slave  core,
   input  logic             dp_done,
   output logic             vl_sel,
   output logic             vtype_sel,
   output logic             lumop_sel,
   output logic             rs1rd_de,
   output logic             rs1_sel,
   output logic             csrwr_en,
   output logic             vec_reg_wr_en,
   output logic             mask_operation,
   output logic             mask_wr_en,
   output logic [1:0]       data_mux1_sel,
   output logic             data_mux2_sel,
   output logic             stride_sel,
   output logic             ld_inst,
   output logic             st_inst,
   output logic             index_str,
   output logic             index_unordered
);
   localparam int WD_W = $clog2(TIMEOUT);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
   state_e          state_q, state_d;
   logic [XLEN-1:0] inst_q, inst_d;
   vec_ctrl_t       ctrl_q, ctrl_d, dec_ctrl, out_ctrl;
   cls_e            dec_cls;
   logic [WD_W-1:0] wd_q, wd_d;
   logic            err_q, err_d;
   vec_ctrl_decode u_dec (.inst(inst_q[31:0]), .is_vec(core.is_vec), .cls(dec_cls), .ctrl(dec_ctrl));
   always_comb begin
      state_d = state_q;
      inst_d = inst_q;
      ctrl_d = ctrl_q;
      wd_d = wd_q;
      err_d = err_q;
      case (state_q)
         S_IDLE: if (core.inst_valid) begin
            inst_d = core.instruction;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            err_d = dec_cls == CLS_ILLEGAL;
            ctrl_d = dec_ctrl;
            wd_d = '0;
            state_d = dec_cls == CLS_ILLEGAL ? S_DONE : S_EXEC;
         end
         // completion is checked before the watchdog so a last-cycle dp_done is not an error
         S_EXEC: if (dp_done) begin
            err_d = 1'b0;
            state_d = S_DONE;
         end else if (wd_q == WD_LAST) begin
            err_d = 1'b1;
            state_d = S_DONE;
         end else wd_d = wd_q + WD_W'(1);
         default: begin
            ctrl_d = '0;
            state_d = S_IDLE;
         end
      endcase
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q <= S_IDLE;
         inst_q <= '0;
         ctrl_q <= '0;
         wd_q <= '0;
         err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         inst_q <= inst_d;
         ctrl_q <= ctrl_d;
         wd_q <= wd_d;
         err_q <= err_d;
      end
   always_comb begin
      out_ctrl = state_q == S_EXEC ? ctrl_q : '0;
      out_ctrl.csrwr_en = out_ctrl.csrwr_en & (wd_q == '0);
   end
   assign {vl_sel, vtype_sel, lumop_sel, rs1rd_de, rs1_sel, csrwr_en, vec_reg_wr_en, mask_operation,
           mask_wr_en, data_mux1_sel, data_mux2_sel, stride_sel, ld_inst, st_inst, index_str,
           index_unordered} = out_ctrl;
   assign core.inst_ready = state_q == S_IDLE;
   assign core.busy = state_q != S_IDLE;
   assign core.inst_ack = state_q == S_DONE;
   assign core.inst_err = state_q == S_DONE && err_q;
endmodule

// File: tb/tb_vec_issue_ctrl.sv
// tb_vec_issue_ctrl: randomized scoreboard bench for vec_issue_ctrl against a rule-level reference model
module tb_vec_issue_ctrl;
   localparam int TO = 16;
   localparam logic [16:0] CSR_M = 17'h00800;
   typedef struct {
      logic [16:0] ctl;
      bit          err;
      bit          csr;
      int          lat;
      int          hs;
   } exp_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic dp_done = 1'b0;
   logic vl_sel, vtype_sel, lumop_sel, rs1rd_de, rs1_sel, csrwr_en, vec_reg_wr_en, mask_operation;
   logic mask_wr_en, data_mux2_sel, stride_sel, ld_inst, st_inst, index_str, index_unordered;
   logic [1:0] data_mux1_sel;
   int cyc = 0;
   int n_cmp = 0;
   int n_bad = 0;
   bit mon_en = 0;
   exp_t q[$];
   vec_issue_ctrl_if #(.XLEN(32)) core ();
   vec_issue_ctrl #(.XLEN(32), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .core(core), .dp_done(dp_done),
      .vl_sel(vl_sel), .vtype_sel(vtype_sel), .lumop_sel(lumop_sel), .rs1rd_de(rs1rd_de),
      .rs1_sel(rs1_sel), .csrwr_en(csrwr_en), .vec_reg_wr_en(vec_reg_wr_en),
      .mask_operation(mask_operation), .mask_wr_en(mask_wr_en), .data_mux1_sel(data_mux1_sel),
      .data_mux2_sel(data_mux2_sel), .stride_sel(stride_sel), .ld_inst(ld_inst), .st_inst(st_inst),
      .index_str(index_str), .index_unordered(index_unordered));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   function automatic logic [16:0] ctl_now();
      return {vl_sel, vtype_sel, lumop_sel, rs1rd_de, rs1_sel, csrwr_en, vec_reg_wr_en, mask_operation,
              mask_wr_en, data_mux1_sel, data_mux2_sel, stride_sel, ld_inst, st_inst, index_str,
              index_unordered};
   endfunction
   // expected controls straight from the instruction-format rules
   function automatic logic [16:0] model(input logic [31:0] i, input bit v, output bit ill, output bit cfg);
      int op = int'(i[6:0]);
      int f3 = int'(i[14:12]);
      int mop = int'(i[27:26]);
      bit is_v = op == 'h57;
      bit is_ld = op == 'h07;
      bit is_st = op == 'h27;
      bit wok = f3 == 0 || f3 >= 5;
      bit arith, mem;
      int mux1;
      ill = !v || !(is_v || ((is_ld || is_st) && wok));
      cfg = !ill && is_v && f3 == 7;
      arith = !ill && is_v && f3 != 7;
      mem = !ill && (is_ld || is_st);
      mux1 = !arith ? 0 : f3 == 3 ? 2 : (f3 >= 4 && f3 <= 6) ? 1 : 0;
      return {cfg && i[31:30] == 2'b11, cfg && i[31:25] == 7'h40, mem && mop == 0,
              cfg && i[19:15] == 0 && i[11:7] != 0, cfg, cfg, arith || (mem && is_ld), arith && !i[25],
              1'b0, 2'(mux1), 1'b0, mem && mop == 0, mem && is_ld, mem && is_st, mem && mop % 2 == 1,
              mem && mop == 1};
   endfunction
   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, got, exp, cyc);
      end
   endtask
   task automatic idle_chk(input string tag);
      chk({tag, "_ready"}, 32'(core.inst_ready), 1);
      chk({tag, "_busy"}, 32'(core.busy), 0);
      chk({tag, "_ack"}, 32'(core.inst_ack), 0);
      chk({tag, "_err"}, 32'(core.inst_err), 0);
      chk({tag, "_ctl"}, 32'(ctl_now()), 0);
   endtask
   initial begin
      int rel;
      forever begin
         @(posedge clk);
         #2;
         if (mon_en) begin
            if (q.size() == 0) idle_chk("idle");
            else begin
               rel = cyc - q[0].hs;
               chk("ack", 32'(core.inst_ack), 32'(rel == q[0].lat));
               chk("err", 32'(core.inst_err), 32'(rel == q[0].lat && q[0].err));
               chk("busy", 32'(core.busy), 1);
               chk("ready", 32'(core.inst_ready), 0);
               if (rel == 1 || rel >= q[0].lat) chk("ctl_off", 32'(ctl_now()), 0);
               else begin
                  chk("ctl_exec", 32'(ctl_now() & ~CSR_M), 32'(q[0].ctl & ~CSR_M));
                  chk("csrwr", 32'(csrwr_en), 32'(q[0].csr && rel == 2));
               end
               if (rel >= q[0].lat) void'(q.pop_front());
            end
         end
      end
   end
   // j: EXEC cycle on which dp_done is raised, 0 means never
   task automatic send(input logic [31:0] ins, input bit v, input int j, input int gap);
      exp_t e;
      bit ill, cfg;
      repeat (gap) begin
         @(negedge clk);
         core.inst_valid = 1'b0;
         core.instruction = $urandom;
         dp_done = 1'($urandom);
      end
      @(negedge clk);
      chk("hs_ready", 32'(core.inst_ready), 1);
      core.inst_valid = 1'b1;
      core.instruction = ins;
      core.is_vec = v;
      dp_done = 1'($urandom);
      e.ctl = model(ins, v, ill, cfg);
      e.err = ill || j == 0;
      e.csr = cfg;
      e.lat = ill ? 2 : j == 0 ? TO + 2 : j + 2;
      e.hs = cyc;
      q.push_back(e);
      for (int c = 1; c <= e.lat; c++) begin
         @(negedge clk);
         core.inst_valid = 1'($urandom);
         core.instruction = $urandom;
         core.is_vec = c == 1 ? v : 1'($urandom);
         dp_done = (!ill && c >= 2 && c < e.lat) ? (c - 1 == j) : 1'($urandom);
      end
   endtask
   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end
   initial begin
      logic [31:0] r;
      logic [2:0] w[4] = '{3'b000, 3'b101, 3'b110, 3'b111};
      bit ill, cfg;
      int k, j;
      core.inst_valid = 1'b0;
      core.instruction = '0;
      core.is_vec = 1'b0;
      repeat (3) @(negedge clk);
      idle_chk("reset");
      reset = 1'b0;
      mon_en = 1;
      send(32'h010572D7, 1, 2, 1);
      send(32'h022180D7, 1, 1, 0);
      send(32'h0205E207, 1, 3, 2);
      send(32'h00000013, 0, 1, 0);
      send(32'h0205E227, 1, 0, 1);
      send(32'h0205E227, 1, TO, 0);
      send(32'h80C070D7, 1, 1, 0);
      send(32'hC2007157, 1, 2, 0);
      for (int n = 0; n < 70; n++) begin
         r = $urandom;
         k = $urandom_range(0, 9);
         r[6:0] = k < 4 ? 7'h57 : k < 6 ? 7'h07 : k < 8 ? 7'h27 : r[6:0];
         if (k >= 4 && k < 8 && $urandom_range(0, 3) != 0) r[14:12] = w[$urandom_range(0, 3)];
         if (k < 2) r[14:12] = 3'b111;
         if ($urandom_range(0, 2) == 0) r[19:15] = 5'd0;
         if ($urandom_range(0, 4) == 0) r[31:25] = 7'h40;
         k = $urandom_range(0, 9);
         j = k == 0 ? 0 : k == 1 ? TO : k == 2 ? TO - 1 : $urandom_range(1, 4);
         send(r, $urandom_range(0, 7) != 0, j, $urandom_range(0, 2));
      end
      @(negedge clk);
      core.inst_valid = 1'b0;
      repeat (2) @(negedge clk);
      mon_en = 0;
      core.inst_valid = 1'b1;
      core.instruction = 32'h0205E207;
      core.is_vec = 1'b1;
      dp_done = 1'b0;
      @(negedge clk);
      core.inst_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_pre_ctl", 32'(ctl_now()), 32'(model(32'h0205E207, 1, ill, cfg)));
      reset = 1'b1;
      #1;
      idle_chk("rst_async");
      @(posedge clk);
      #2;
      idle_chk("rst_next");
      @(negedge clk);
      reset = 1'b0;
      mon_en = 1;
      repeat (2) @(negedge clk);
      send(32'h022180D7, 1, 1, 0);
      @(negedge clk);
      core.inst_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("queue_drained", 32'(q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
